// File: rtl/simple_cpu_pkg.sv
// Shared encodings for the Simple CPU memory subsystem: FSM states, access direction, port IDs.
package simple_cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_HOST = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way picker: a lone request wins; on a tie either the host wins (prio)
// or the port that was not served last wins.
module rr_pick2
  import simple_cpu_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       prio_i,
  output logic       grant_o
);

  always_comb begin
    grant_o = PORT_CPU;
    if (req_i[PORT_HOST] && !req_i[PORT_CPU]) begin
      grant_o = PORT_HOST;
    end else if (req_i[PORT_HOST] && req_i[PORT_CPU]) begin
      grant_o = prio_i ? PORT_HOST : ~last_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported synchronous memory between the CPU and host ports.
// One access per three cycles: IDLE (arbitrate, latch) -> ACCESS (mem strobe) -> RESP (ack).
module mem_arbiter
  import simple_cpu_pkg::*;
#(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int HOST_PRIO = 0
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          cpu_req,
  input  logic          cpu_rw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_rw,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic PRIO = (HOST_PRIO != 0);

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic          last_q, last_d;
  logic          lat_rw_q, lat_rw_d;
  logic [AW-1:0] lat_addr_q, lat_addr_d;
  logic [DW-1:0] lat_wdata_q, lat_wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic          grant;
  logic          any_req;
  logic          take;

  assign any_req = cpu_req | host_req;
  assign take    = (state_q == ST_IDLE) && any_req;

  rr_pick2 u_pick (
    .req_i   ({host_req, cpu_req}),
    .last_i  (last_q),
    .prio_i  (PRIO),
    .grant_o (grant)
  );

  always_comb begin
    state_d      = ST_IDLE;
    sel_d        = sel_q;
    last_d       = last_q;
    lat_rw_d     = lat_rw_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;

    case (state_q)
      ST_IDLE:   state_d = any_req ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (take) begin
      sel_d       = grant;
      last_d      = grant;
      lat_rw_d    = (grant == PORT_HOST) ? host_rw    : cpu_rw;
      lat_addr_d  = (grant == PORT_HOST) ? host_addr  : cpu_addr;
      lat_wdata_d = (grant == PORT_HOST) ? host_wdata : cpu_wdata;
    end

    // Memory read data is valid during RESP, one cycle after the strobe.
    if ((state_q == ST_RESP) && (lat_rw_q == RW_READ)) begin
      if (sel_q == PORT_CPU) begin
        cpu_rdata_d = mem_rdata;
      end else begin
        host_rdata_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= ST_IDLE;
      sel_q        <= PORT_CPU;
      last_q       <= PORT_HOST;
      lat_rw_q     <= RW_READ;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_q       <= last_d;
      lat_rw_q     <= lat_rw_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign mem_en    = (state_q == ST_ACCESS);
  assign mem_rw    = mem_en & lat_rw_q;
  assign mem_addr  = mem_en ? lat_addr_q  : '0;
  assign mem_wdata = mem_en ? lat_wdata_q : '0;

  assign cpu_ack    = (state_q == ST_RESP) && (sel_q == PORT_CPU);
  assign host_ack   = (state_q == ST_RESP) && (sel_q == PORT_HOST);
  assign cpu_rdata  = cpu_rdata_q;
  assign host_rdata = host_rdata_q;

endmodule
